enemy_gunner: RTL and testbench
===============================

# enemy_gunner

Parametrised successor to the single-bullet enemy ship. It drives one enemy ship with selectable movement modes (sweep, zigzag, hold) and a pool of NB independent bullets. Firing is paced by a cooldown counter, and any bullet can be cleared early by a collision input. It sits beside the player and collision logic and feeds bounding boxes to the pixel renderer.

## Interface
- H_SIZE, 80, ship half-width (square).
- B_HSIZE, 20, bullet half-width (square).
- IX, 320, reset centre x.
- IY, 240, reset centre y; also the zigzag top.
- IX_DIR, 1, reset horizontal direction (1 = right).
- D_WIDTH, 640, display width.
- D_HEIGHT, 480, display height.
- H_BOUND, 100, ship centre turn-around margin.
- X_SPEED, 2, ship x step per tick.
- ZIG_AMP, 40, zigzag vertical span below IY.
- B_SPEED, 3, bullet y step per tick.
- NB, 4, bullet slots, 1..16.
- FIRE_GAP, 30, minimum ticks between shots, ≥1.

Ports:
- i_clk  in  1  base clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ani_stb  in  1  animation strobe.
- i_animate  in  1  animation enable.
- i_paused  in  1  game paused.
- i_alive  in  1  ship alive; firing permitted.
- i_mode  in  2  0 sweep, 1 zigzag, 2/3 hold.
- i_bhit  in  NB  per-slot collision clear.
- o_x1, o_x2, o_y1, o_y2  out  12 each  ship box edges (centre ∓ H_SIZE).
- o_bx1, o_bx2, o_by1, o_by2  out  NB×12 each  bullet box edges; slot k occupies bits [12k+11:12k].
- o_bactive  out  NB  slot in flight.
- o_fire_pulse  out  1  one-cycle pulse per shot.

## Operation
- tick = i_animate & i_ani_stb & ~i_paused. All motion, cooldown and firing advance only on tick. i_bhit acts on every clock.
- Sweep:
  - x += X_SPEED when dir = 1; otherwise x −= X_SPEED.
  - On the same tick, dir is set from the pre-move x: dir ← 1 if x ≤ H_BOUND; dir ← 0 if x ≥ D_WIDTH − H_BOUND.
  - y is unchanged.
- Zigzag:
  - x behaves as in sweep.
  - y steps ±1 per tick. ydir flips to up when pre-move y ≥ IY + ZIG_AMP, and to down when y ≤ IY.
- Hold: x and y are frozen. Firing continues.
- Mode change takes effect on the next tick. Position is retained. ydir is kept, so re-entering zigzag continues from the current y.
- Cooldown counter cd:
  - On each tick, if cd ≠ 0 then cd−1.
  - If cd = 0 and i_alive and at least one slot is free, load the lowest-index free slot with (x, y + H_SIZE). Then cd ← FIRE_GAP − 1 and o_fire_pulse = 1 next cycle.
  - If cd = 0 with no free slot or ~i_alive, cd holds at 0 and the shot fires on the first eligible tick.
- Free slot: o_bactive[k] = 0 in the registered state. A slot cleared by i_bhit this cycle is not eligible until the next cycle.
- Active bullet on a tick:
  - If by + B_SPEED > D_HEIGHT − B_HSIZE, it retires: bactive ← 0.
  - Otherwise by += B_SPEED. bx is constant.
- i_bhit[k] clears slot k with priority over move/retire. A hit on an inactive slot is ignored.
- Inactive slot coordinates track the ship centre (x, y) each cycle.
- ~i_alive stops new shots only. In-flight bullets continue.
- Arithmetic is unsigned 12-bit. Parameters guarantee no wrap; elaboration asserts H_BOUND ≥ H_SIZE and IY + ZIG_AMP + H_SIZE < D_HEIGHT.

## Timing
- Reset values:
  - x = IX, y = IY, dir = IX_DIR, ydir = down.
  - cd = FIRE_GAP − 1.
  - o_bactive = 0, all bullet coordinates = (IX, IY).
  - o_fire_pulse = 0.
  - Box outputs equal reset-derived edges, e.g. o_x1 = IX − H_SIZE.
- Register updates occur on the tick cycle. Box outputs are combinational from registers, so they are valid the cycle after the tick.
- o_fire_pulse is registered, high for exactly one cycle, and coincident with the new slot's o_bactive rising.
- Reset asserted mid-flight clears everything immediately (asynchronous). Release is synchronised by the usual reset bridge upstream.

## Structure
- Shared package enemy_pkg:
  - COORD_W = 12.
  - Mode encodings MODE_SWEEP, MODE_ZIG, MODE_HOLD.
  - Box-edge helper function.
- Sub-module enemy_bullet_slot, instantiated NB times:
  - Holds bx, by, active.
  - Inputs: load, load_x, load_y, tick, hit.
  - Implements move, retire and hit priority.
- Top level contains the ship motion, the cooldown counter and the lowest-free-slot priority encoder.

## Test plan
- Reset then 50 ticks in sweep: x = 320 + 2·50 = 420, dir = 1. Turn-around when x reaches 540 (≥ D_WIDTH − H_BOUND); x then decreases.
- FIRE_GAP = 30, i_alive held high: first shot on tick 30 into slot 0 at (x, 320). Slot 1 fires 30 ticks later. o_fire_pulse is one cycle wide each time.
- NB = 2, bullets never retire: third shot is deferred with cd held at 0. i_bhit[0] pulse → slot 0 reloads on the next tick, not the hit cycle.
- Bullet launched at y = 320: it retires on the tick where by + 3 > 460, and o_bactive drops that cycle.
- Zigzag with i_paused toggled: y oscillates 240↔280 in ±1 steps and freezes while paused. Mode switched to hold: x and y are constant while firing continues.
- i_rst_n asserted mid-flight with 3 bullets active: immediate clear to reset values. First shot arrives exactly FIRE_GAP ticks after release.

Source files
------------

// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared types and helpers for the enemy gunner block.
//   COORD_W   : width of every screen coordinate (unsigned)
//   mode_e    : ship movement mode encodings (2'd3 also behaves as hold)
//   ydir_e    : vertical zigzag direction (down = increasing y)
//   span_t    : low/high edge pair of a square box along one axis
//   box_span  : centre -/+ half-size -> span_t
// ---------------------------------------------------------------------------
package enemy_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    MODE_SWEEP = 2'd0,
    MODE_ZIG   = 2'd1,
    MODE_HOLD  = 2'd2
  } mode_e;

  typedef enum logic {
    YDIR_UP   = 1'b0,
    YDIR_DOWN = 1'b1
  } ydir_e;

  typedef struct packed {
    coord_t lo;
    coord_t hi;
  } span_t;

  function automatic span_t box_span(input coord_t c, input coord_t h);
    span_t s;
    s.lo = c - h;
    s.hi = c + h;
    return s;
  endfunction

endpackage

// File: rtl/enemy_gunner_if.sv
// ---------------------------------------------------------------------------
// enemy_gunner_if
// Bundles the control inputs and box outputs of enemy_gunner.
//   i_ani_stb/i_animate/i_paused : animation timing (tick qualifiers)
//   i_alive, i_mode, i_bhit      : ship state, movement mode, per-slot hits
//   o_x1..o_y2                   : ship box edges
//   o_bx1..o_by2                 : bullet box edges, slot k at [12k+11:12k]
//   o_bactive, o_fire_pulse      : slot in-flight flags, one-cycle shot pulse
// Timing contract: there is no valid/ready pair here. i_ani_stb is a
// one-cycle strobe that is only honoured when i_animate is high and
// i_paused is low; i_bhit is sampled on every clock. All outputs are
// derived from registers and are valid the cycle after the qualifying edge.
// slave = the gunner; master = whoever drives it (game logic / bench).
// ---------------------------------------------------------------------------
interface enemy_gunner_if #(
  parameter int NB = 4
);
  import enemy_pkg::*;

  logic                  i_ani_stb;
  logic                  i_animate;
  logic                  i_paused;
  logic                  i_alive;
  logic [1:0]            i_mode;
  logic [NB-1:0]         i_bhit;
  coord_t                o_x1, o_x2, o_y1, o_y2;
  logic [NB*COORD_W-1:0] o_bx1, o_bx2, o_by1, o_by2;
  logic [NB-1:0]         o_bactive;
  logic                  o_fire_pulse;

  modport slave (
    input  i_ani_stb, i_animate, i_paused, i_alive, i_mode, i_bhit,
    output o_x1, o_x2, o_y1, o_y2, o_bx1, o_bx2, o_by1, o_by2,
    output o_bactive, o_fire_pulse
  );

  modport master (
    output i_ani_stb, i_animate, i_paused, i_alive, i_mode, i_bhit,
    input  o_x1, o_x2, o_y1, o_y2, o_bx1, o_bx2, o_by1, o_by2,
    input  o_bactive, o_fire_pulse
  );

endinterface

// File: rtl/enemy_bullet_slot.sv
// ---------------------------------------------------------------------------
// enemy_bullet_slot
// One bullet: centre (bx, by) and an in-flight flag.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_tick                : animation tick (move / retire)
//   i_load, i_load_x/y    : launch at the given centre (only when free)
//   i_hit                 : collision clear, wins over move and retire
//   i_ship_x/y            : ship centre, followed while the slot is idle
//   o_bx, o_by, o_active  : registered bullet state
// ---------------------------------------------------------------------------
module enemy_bullet_slot
  import enemy_pkg::*;
#(
  parameter int B_HSIZE  = 20,
  parameter int IX       = 320,
  parameter int IY       = 240,
  parameter int D_HEIGHT = 480,
  parameter int B_SPEED  = 3
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_tick,
  input  logic   i_load,
  input  coord_t i_load_x,
  input  coord_t i_load_y,
  input  logic   i_hit,
  input  coord_t i_ship_x,
  input  coord_t i_ship_y,
  output coord_t o_bx,
  output coord_t o_by,
  output logic   o_active
);

  localparam coord_t BOTTOM = COORD_W'(D_HEIGHT - B_HSIZE);
  localparam coord_t SPEED  = COORD_W'(B_SPEED);

  coord_t r_bx, r_by;
  logic   r_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_bx     <= COORD_W'(IX);
      r_by     <= COORD_W'(IY);
    end else if (i_hit && r_active) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      if (i_tick) begin
        // Retire once the next step would push the box past the bottom.
        if (r_by + SPEED > BOTTOM) r_active <= 1'b0;
        else                       r_by     <= r_by + SPEED;
      end
    end else if (i_load) begin
      r_active <= 1'b1;
      r_bx     <= i_load_x;
      r_by     <= i_load_y;
    end else begin
      r_bx <= i_ship_x;
      r_by <= i_ship_y;
    end
  end

  assign o_bx     = r_bx;
  assign o_by     = r_by;
  assign o_active = r_active;

endmodule

// File: rtl/enemy_gunner.sv
// ---------------------------------------------------------------------------
// enemy_gunner
// Enemy ship with sweep / zigzag / hold motion and an NB-slot bullet pool.
//   i_clk, i_rst_n : clock, async active-low reset
//   io_bus         : enemy_gunner_if.slave (controls in, box edges out)
// Motion, cooldown and launches advance only on tick =
// animate & ani_stb & ~paused. A shot goes to the lowest-index slot that
// is free in the registered state, launched from below the ship.
// ---------------------------------------------------------------------------
module enemy_gunner
  import enemy_pkg::*;
#(
  parameter int H_SIZE   = 80,
  parameter int B_HSIZE  = 20,
  parameter int IX       = 320,
  parameter int IY       = 240,
  parameter int IX_DIR   = 1,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int H_BOUND  = 100,
  parameter int X_SPEED  = 2,
  parameter int ZIG_AMP  = 40,
  parameter int B_SPEED  = 3,
  parameter int NB       = 4,
  parameter int FIRE_GAP = 30
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  enemy_gunner_if.slave  io_bus
);

  if (H_BOUND < H_SIZE) begin : g_chk_bound
    $error("enemy_gunner: H_BOUND must be >= H_SIZE");
  end
  if (IY + ZIG_AMP + H_SIZE >= D_HEIGHT) begin : g_chk_zig
    $error("enemy_gunner: zigzag range leaves the display");
  end
  if (NB < 1 || NB > 16) begin : g_chk_nb
    $error("enemy_gunner: NB must be 1..16");
  end
  if (FIRE_GAP < 1) begin : g_chk_gap
    $error("enemy_gunner: FIRE_GAP must be >= 1");
  end

  localparam int     CD_W   = (FIRE_GAP > 1) ? $clog2(FIRE_GAP) : 1;
  localparam coord_t X_LO   = COORD_W'(H_BOUND);
  localparam coord_t X_HI   = COORD_W'(D_WIDTH - H_BOUND);
  localparam coord_t Y_TOP  = COORD_W'(IY);
  localparam coord_t Y_BOT  = COORD_W'(IY + ZIG_AMP);
  localparam coord_t XS     = COORD_W'(X_SPEED);
  localparam coord_t HS     = COORD_W'(H_SIZE);
  localparam coord_t BHS    = COORD_W'(B_HSIZE);
  localparam logic [CD_W-1:0] GAP_M1 = CD_W'(FIRE_GAP - 1);

  logic             w_tick;
  coord_t           r_x, r_y;
  logic             r_dir;
  ydir_e            r_ydir;
  logic [CD_W-1:0]  r_cd;
  logic             r_fire;
  logic [NB-1:0]    w_bactive;
  logic [NB-1:0]    w_sel;
  logic [NB-1:0]    w_load;
  logic             w_fire;
  logic             w_moving;
  coord_t           w_load_y;
  span_t            w_ship_sx, w_ship_sy;
  logic [NB*COORD_W-1:0] w_bx1, w_bx2, w_by1, w_by2;

  assign w_tick   = io_bus.i_animate & io_bus.i_ani_stb & ~io_bus.i_paused;
  assign w_moving = (io_bus.i_mode == MODE_SWEEP) || (io_bus.i_mode == MODE_ZIG);
  assign w_load_y = r_y + HS;

  // Ship motion: step with the current direction, and pick the next
  // direction from the pre-move position on the same tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x    <= COORD_W'(IX);
      r_y    <= COORD_W'(IY);
      r_dir  <= (IX_DIR != 0);
      r_ydir <= YDIR_DOWN;
    end else if (w_tick) begin
      if (w_moving) begin
        r_x <= r_dir ? (r_x + XS) : (r_x - XS);
        if (r_x <= X_LO)      r_dir <= 1'b1;
        else if (r_x >= X_HI) r_dir <= 1'b0;
      end
      if (io_bus.i_mode == MODE_ZIG) begin
        r_y <= (r_ydir == YDIR_DOWN) ? (r_y + 12'd1) : (r_y - 12'd1);
        if (r_y >= Y_BOT)      r_ydir <= YDIR_UP;
        else if (r_y <= Y_TOP) r_ydir <= YDIR_DOWN;
      end
    end
  end

  // Lowest-index free slot, one-hot. Uses the registered active flags so
  // a slot cleared by a hit this cycle only becomes eligible next cycle.
  always_comb begin
    w_sel = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if (!w_bactive[k]) begin
        w_sel    = '0;
        w_sel[k] = 1'b1;
      end
    end
  end

  assign w_fire = w_tick && (r_cd == '0) && io_bus.i_alive && (w_sel != '0);
  assign w_load = w_sel & {NB{w_fire}};

  // Cooldown sits at zero while a shot is blocked, so it fires on the
  // first eligible tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cd   <= GAP_M1;
      r_fire <= 1'b0;
    end else begin
      r_fire <= w_fire;
      if (w_tick) begin
        if (r_cd != '0) r_cd <= r_cd - 1'b1;
        else if (w_fire) r_cd <= GAP_M1;
      end
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_slot
    coord_t w_bx, w_by;
    span_t  w_sx, w_sy;

    enemy_bullet_slot #(
      .B_HSIZE (B_HSIZE),
      .IX      (IX),
      .IY      (IY),
      .D_HEIGHT(D_HEIGHT),
      .B_SPEED (B_SPEED)
    ) u_slot (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (w_tick),
      .i_load  (w_load[k]),
      .i_load_x(r_x),
      .i_load_y(w_load_y),
      .i_hit   (io_bus.i_bhit[k]),
      .i_ship_x(r_x),
      .i_ship_y(r_y),
      .o_bx    (w_bx),
      .o_by    (w_by),
      .o_active(w_bactive[k])
    );

    assign w_sx = box_span(w_bx, BHS);
    assign w_sy = box_span(w_by, BHS);
    assign w_bx1[k*COORD_W +: COORD_W] = w_sx.lo;
    assign w_bx2[k*COORD_W +: COORD_W] = w_sx.hi;
    assign w_by1[k*COORD_W +: COORD_W] = w_sy.lo;
    assign w_by2[k*COORD_W +: COORD_W] = w_sy.hi;
  end

  assign w_ship_sx = box_span(r_x, HS);
  assign w_ship_sy = box_span(r_y, HS);

  assign io_bus.o_x1         = w_ship_sx.lo;
  assign io_bus.o_x2         = w_ship_sx.hi;
  assign io_bus.o_y1         = w_ship_sy.lo;
  assign io_bus.o_y2         = w_ship_sy.hi;
  assign io_bus.o_bx1        = w_bx1;
  assign io_bus.o_bx2        = w_bx2;
  assign io_bus.o_by1        = w_by1;
  assign io_bus.o_by2        = w_by2;
  assign io_bus.o_bactive    = w_bactive;
  assign io_bus.o_fire_pulse = r_fire;

endmodule

// File: tb/tb_enemy_gunner.sv
// ---------------------------------------------------------------------------
// tb_enemy_gunner
// u_main : default parameters (NB=4, FIRE_GAP=30), driven through a table of
//          motion segments with random idle cycles between strobes.
// u_small: NB=3, FIRE_GAP=10, used for the blocked-shot, hit-reload and
//          mid-flight reset sequences.
// ---------------------------------------------------------------------------
module tb_enemy_gunner;
  import enemy_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enemy_gunner_if #(.NB(4)) bus_m ();
  enemy_gunner_if #(.NB(3)) bus_s ();

  enemy_gunner u_main (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus_m)
  );

  enemy_gunner #(.NB(3), .FIRE_GAP(10)) u_small (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus_s)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int s_fires  = 0;

  // {slot[1:0], bx, by} of every shot the model expects
  logic [25:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // ---------------- reference model of u_main ----------------
  logic [11:0] m_x, m_y;
  logic [11:0] m_by[4];
  logic        m_dir, m_ydir;   // m_ydir 1 = moving down (y increasing)
  int          m_cd;
  logic [3:0]  m_act;
  logic        m_fire;

  task automatic model_step(input logic tk, input logic alive, input logic [1:0] mode);
    logic [11:0] px, py;
    logic [3:0]  pact;
    int          slot;
    px     = m_x;
    py     = m_y;
    pact   = m_act;
    m_fire = 1'b0;
    if (tk) begin
      for (int k = 0; k < 4; k++) begin
        if (pact[k]) begin
          if (m_by[k] + 3 > 460) m_act[k] = 1'b0;
          else m_by[k] = m_by[k] + 12'd3;
        end
      end
      if (m_cd != 0) m_cd--;
      else if (alive && pact != 4'hF) begin
        slot = 0;
        for (int k = 3; k >= 0; k--) if (!pact[k]) slot = k;
        m_act[slot] = 1'b1;
        m_by[slot]  = py + 12'd80;
        m_fire      = 1'b1;
        m_cd        = 29;
        exp_q.push_back({2'(slot), px, 12'(py + 12'd80)});
      end
      if (mode == 2'd0 || mode == 2'd1) begin
        m_x = m_dir ? px + 12'd2 : px - 12'd2;
        if (px <= 100) m_dir = 1'b1;
        else if (px >= 540) m_dir = 1'b0;
      end
      if (mode == 2'd1) begin
        m_y = m_ydir ? py + 12'd1 : py - 12'd1;
        if (py >= 280) m_ydir = 1'b0;
        else if (py <= 240) m_ydir = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic main_cycle(input logic stb);
    logic [25:0] e;
    int          s;
    bus_m.i_ani_stb = stb;
    model_step(stb & bus_m.i_animate & ~bus_m.i_paused, bus_m.i_alive, bus_m.i_mode);
    @(posedge clk);
    #1;
    check("m_bactive", bus_m.o_bactive, m_act);
    check("m_fire_pulse", bus_m.o_fire_pulse, m_fire);
    check("m_ship_x1y1", {bus_m.o_x1, bus_m.o_y1}, {m_x - 12'd80, m_y - 12'd80});
    if (bus_m.o_fire_pulse) begin
      check("m_sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        s = int'(e[25:24]);
        check("m_shot_xy", {bus_m.o_bx1[12*s +: 12] + 12'd20, bus_m.o_by1[12*s +: 12] + 12'd20},
              e[23:0]);
      end
    end
  endtask

  task automatic s_cycle(input logic stb, input logic [2:0] hit);
    bus_s.i_ani_stb = stb;
    bus_s.i_bhit    = hit;
    @(posedge clk);
    #1;
    bus_s.i_bhit = '0;
    s_fires += int'(bus_s.o_fire_pulse);
  endtask

  // ---------------- segment table for u_main ----------------
  typedef struct {
    logic [1:0] mode;
    logic       paused;
    logic       alive;
    int         n;        // strobe cycles in this segment
    int         x, y;     // ship centre afterwards
    logic [3:0] bact;
    int         b0x1, b0y1;
  } seg_t;

  seg_t tbl[8];

  initial begin
    int t;
    tbl[0] = '{2'd0, 1'b0, 1'b1, 50, 420, 240, 4'b0001, 358, 360};
    tbl[1] = '{2'd0, 1'b0, 1'b1, 70, 524, 240, 4'b0011, 478, 390};
    tbl[2] = '{2'd1, 1'b0, 1'b1, 45, 434, 277, 4'b0011, 446, 374};
    tbl[3] = '{2'd1, 1'b1, 1'b1, 20, 434, 277, 4'b0011, 446, 374};
    tbl[4] = '{2'd2, 1'b0, 1'b1, 30, 434, 277, 4'b0010, 414, 257};
    tbl[5] = '{2'd1, 1'b0, 1'b1, 10, 414, 267, 4'b0010, 396, 248};
    tbl[6] = '{2'd1, 1'b0, 1'b0, 20, 374, 247, 4'b0000, 356, 228};
    tbl[7] = '{2'd3, 1'b0, 1'b1, 1,  374, 247, 4'b0001, 354, 307};

    bus_m.i_ani_stb = 1'b0; bus_m.i_animate = 1'b1; bus_m.i_paused = 1'b0;
    bus_m.i_alive = 1'b1; bus_m.i_mode = 2'd0; bus_m.i_bhit = '0;
    bus_s.i_ani_stb = 1'b0; bus_s.i_animate = 1'b0; bus_s.i_paused = 1'b0;
    bus_s.i_alive = 1'b1; bus_s.i_mode = 2'd2; bus_s.i_bhit = '0;

    m_x = 12'd320; m_y = 12'd240; m_dir = 1'b1; m_ydir = 1'b1;
    m_cd = 29; m_act = '0; m_fire = 1'b0;
    for (int k = 0; k < 4; k++) m_by[k] = 12'd240;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // reset state
    check("rst_x1", bus_m.o_x1, 12'd240);
    check("rst_x2", bus_m.o_x2, 12'd400);
    check("rst_y1", bus_m.o_y1, 12'd160);
    check("rst_y2", bus_m.o_y2, 12'd320);
    check("rst_bactive", bus_m.o_bactive, 4'b0000);
    check("rst_fire", bus_m.o_fire_pulse, 1'b0);
    check("rst_bx1", bus_m.o_bx1, {4{12'd300}});
    check("rst_bx2", bus_m.o_bx2, {4{12'd340}});
    check("rst_by1", bus_m.o_by1, {4{12'd220}});
    check("rst_by2", bus_m.o_by2, {4{12'd260}});

    // table-driven motion / firing segments
    for (int s = 0; s < 8; s++) begin
      bus_m.i_mode   = tbl[s].mode;
      bus_m.i_paused = tbl[s].paused;
      bus_m.i_alive  = tbl[s].alive;
      t = 0;
      while (t < tbl[s].n) begin
        if ($urandom_range(0, 3) == 0) main_cycle(1'b0);
        else begin
          main_cycle(1'b1);
          t++;
        end
      end
      check("seg_x1", bus_m.o_x1, 12'(tbl[s].x - 80));
      check("seg_x2", bus_m.o_x2, 12'(tbl[s].x + 80));
      check("seg_y1", bus_m.o_y1, 12'(tbl[s].y - 80));
      check("seg_y2", bus_m.o_y2, 12'(tbl[s].y + 80));
      check("seg_bactive", bus_m.o_bactive, tbl[s].bact);
      check("seg_slot0_xy", {bus_m.o_bx1[11:0], bus_m.o_by1[11:0]},
            {12'(tbl[s].b0x1), 12'(tbl[s].b0y1)});
    end
    main_cycle(1'b0);
    check("m_sb_drained", exp_q.size(), 0);

    // ---------------- u_small hand-written sequences ----------------
    rst_n = 1'b0;
    bus_s.i_animate = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    s_fires = 0;
    for (int i = 0; i < 30; i++) s_cycle(1'b1, 3'b000);
    check("s_three_shots", s_fires, 3);
    check("s_full_bactive", bus_s.o_bactive, 3'b111);
    check("s_third_pulse", bus_s.o_fire_pulse, 1'b1);

    s_fires = 0;
    for (int i = 0; i < 13; i++) s_cycle(1'b1, 3'b000);
    check("s_deferred_none", s_fires, 0);
    check("s_deferred_bactive", bus_s.o_bactive, 3'b111);

    s_cycle(1'b1, 3'b001);
    check("s_hit_clears", bus_s.o_bactive, 3'b110);
    check("s_hit_no_fire", bus_s.o_fire_pulse, 1'b0);

    s_cycle(1'b1, 3'b000);
    check("s_reload_bactive", bus_s.o_bactive, 3'b111);
    check("s_reload_pulse", bus_s.o_fire_pulse, 1'b1);
    check("s_reload_xy", {bus_s.o_bx1[11:0], bus_s.o_by1[11:0]}, {12'd300, 12'd300});

    // asynchronous reset in flight: must clear without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("s_arst_bactive", bus_s.o_bactive, 3'b000);
    check("s_arst_fire", bus_s.o_fire_pulse, 1'b0);
    check("s_arst_x1", bus_s.o_x1, 12'd240);
    check("s_arst_bx1", bus_s.o_bx1, {3{12'd300}});
    check("s_arst_by1", bus_s.o_by1, {3{12'd220}});
    #2;
    rst_n = 1'b1;

    s_fires = 0;
    for (int i = 0; i < 9; i++) s_cycle(1'b1, 3'b110);
    check("s_post_rst_quiet", s_fires, 0);
    check("s_idle_hit_ignored", bus_s.o_bactive, 3'b000);
    s_cycle(1'b1, 3'b000);
    check("s_post_rst_first_shot", bus_s.o_fire_pulse, 1'b1);
    check("s_post_rst_slot0", bus_s.o_bactive, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
